// File: rtl/fp_cvt_f2i_if.sv
// Operand/result handshake bundle for the float-to-integer converter.
// slave is the converter side; master is the producer/consumer side.
interface fp_cvt_f2i_if;
    logic        valid_i;
    logic        ready_o;
    logic [64:0] data_i;
    logic [9:0]  class_i;
    logic [1:0]  op_i;
    logic [2:0]  rm_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] result_o;
    logic [4:0]  flags_o;

    modport slave (
        input  valid_i, data_i, class_i, op_i, rm_i, ready_i,
        output ready_o, valid_o, result_o, flags_o
    );

    modport master (
        output valid_i, data_i, class_i, op_i, rm_i, ready_i,
        input  ready_o, valid_o, result_o, flags_o
    );
endinterface

// File: rtl/fp_cvt_f2i.sv
// Three-stage float-to-integer converter (FCVT.{W,WU,L,LU}.{S,D}) with
// valid/ready flow control, rounding, saturation and NV/NX flags.
module fp_cvt_f2i (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    fp_cvt_f2i_if.slave cvt
);
    function automatic logic round_inc(input logic [2:0] rm, input logic neg,
                                       input logic lsb, input logic rnd, input logic stk);
        case (rm)
            3'd1:    return 1'b0;
            3'd2:    return neg & (rnd | stk);
            3'd3:    return ~neg & (rnd | stk);
            3'd4:    return rnd;
            default: return rnd & (stk | lsb);
        endcase
    endfunction

    function automatic logic in_range(input logic [1:0] op, input logic neg, input logic [64:0] mag);
        case (op)
            2'd0:    return neg ? (mag <= 65'h0_8000_0000) : (mag <= 65'h0_7FFF_FFFF);
            2'd1:    return neg ? (mag == '0) : (mag <= 65'h0_FFFF_FFFF);
            2'd2:    return neg ? (mag <= {2'b01, 63'd0}) : (mag < {2'b01, 63'd0});
            default: return neg ? (mag == '0) : ~mag[64];
        endcase
    endfunction

    function automatic logic [63:0] sat_value(input logic [1:0] op, input logic neg);
        case (op)
            2'd0:    return neg ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_7FFF_FFFF;
            2'd1:    return neg ? 64'd0 : 64'hFFFF_FFFF_FFFF_FFFF;
            2'd2:    return neg ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
            default: return neg ? 64'd0 : 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    logic vld_p0, vld_p1, vld_p2;
    logic en_p0, en_p1, en_p2, take;

    // A stage may load when empty or when its contents move on this cycle.
    assign en_p2       = ~vld_p2 | cvt.ready_i;
    assign en_p1       = ~vld_p1 | en_p2;
    assign en_p0       = ~vld_p0 | en_p1;
    assign cvt.ready_o = en_p0 & ~clear;
    assign take        = cvt.valid_i & cvt.ready_o;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (clear) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (en_p0) vld_p0 <= take;
            if (en_p1) vld_p1 <= vld_p0;
            if (en_p2) vld_p2 <= vld_p1;
        end
    end

    // Stage 1: capture and decode
    logic signed [12:0] exp_c, exp_p0;
    logic               sign_p0, special_p0, nan_p0, zero_p0, big_p0;
    logic [51:0]        frac_p0;
    logic [1:0]         op_p0;
    logic [2:0]         rm_p0;

    assign exp_c = $signed({1'b0, cvt.data_i[63:52]}) - 13'sd2047;

    always_ff @(posedge clock) begin
        if (take) begin
            sign_p0    <= cvt.data_i[64];
            exp_p0     <= exp_c;
            frac_p0    <= cvt.data_i[51:0];
            special_p0 <= cvt.class_i[0] | cvt.class_i[7] | cvt.class_i[8] | cvt.class_i[9];
            nan_p0     <= cvt.class_i[8] | cvt.class_i[9];
            zero_p0    <= cvt.class_i[3] | cvt.class_i[4];
            big_p0     <= exp_c >= 13'sd64;
            op_p0      <= cvt.op_i;
            rm_p0      <= cvt.rm_i;
        end
    end

    // Stage 2: align significand into integer, round and sticky bits
    logic [115:0] shifted;
    logic [63:0]  int_c, int_p1;
    logic         rnd_c, stk_c, rnd_p1, stk_p1;
    logic         sign_p1, special_p1, nan_p1, big_p1;
    logic [1:0]   op_p1;
    logic [2:0]   rm_p1;

    always_comb begin
        shifted = {63'd0, 1'b1, frac_p0} << exp_p0[5:0];
        int_c   = shifted[115:52];
        rnd_c   = shifted[51];
        stk_c   = |shifted[50:0];
        if (zero_p0) begin
            int_c = '0;
            rnd_c = 1'b0;
            stk_c = 1'b0;
        end else if (exp_p0 == -13'sd1) begin
            int_c = '0;
            rnd_c = 1'b1;
            stk_c = |frac_p0;
        end else if (exp_p0 < -13'sd1) begin
            int_c = '0;
            rnd_c = 1'b0;
            stk_c = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (en_p1) begin
            int_p1     <= int_c;
            rnd_p1     <= rnd_c;
            stk_p1     <= stk_c;
            sign_p1    <= sign_p0;
            special_p1 <= special_p0;
            nan_p1     <= nan_p0;
            big_p1     <= big_p0;
            op_p1      <= op_p0;
            rm_p1      <= rm_p0;
        end
    end

    // Stage 3: round, range-check, saturate and pack
    logic [64:0] mag_c;
    logic [63:0] val_c, res_c, res_p2;
    logic        nv_c;
    logic [4:0]  flg_c, flg_p2;

    always_comb begin
        mag_c = {1'b0, int_p1} + 65'(round_inc(rm_p1, sign_p1, int_p1[0], rnd_p1, stk_p1));
        nv_c  = special_p1 | big_p1 | ~in_range(op_p1, sign_p1, mag_c);
        val_c = sign_p1 ? -mag_c[63:0] : mag_c[63:0];
        if (!op_p1[1]) val_c = {{32{val_c[31]}}, val_c[31:0]};
        res_c = nv_c ? sat_value(op_p1, sign_p1 & ~nan_p1) : val_c;
        flg_c = {nv_c, 3'b000, (rnd_p1 | stk_p1) & ~nv_c};
    end

    always_ff @(posedge clock) begin
        if (en_p2) begin
            res_p2 <= res_c;
            flg_p2 <= flg_c;
        end
    end

    assign cvt.valid_o  = vld_p2;
    assign cvt.result_o = vld_p2 ? res_p2 : '0;
    assign cvt.flags_o  = vld_p2 ? flg_p2 : '0;
endmodule

// File: tb/tb_fp_cvt_f2i.sv
// Bench for fp_cvt_f2i: fixed vectors, flow-control sequences and randomized
// traffic scored against an arithmetic reference model.
module tb_fp_cvt_f2i;
    logic clock = 1'b0;
    logic reset;
    logic clear;
    int   n_cmp = 0;
    int   n_bad = 0;

    fp_cvt_f2i_if dif ();

    fp_cvt_f2i dut (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .cvt   (dif)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  flg;
    } exp_t;

    typedef struct {
        string       name;
        logic [64:0] data;
        logic [9:0]  cls;
        logic [1:0]  op;
        logic [2:0]  rm;
        logic [63:0] res;
        logic [4:0]  flg;
    } vec_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, want);
        end
    endtask

    // Value = sig * 2^(e-52); rounding decided from the exact remainder vs one half.
    function automatic void model(input logic [64:0] d, input logic [9:0] c, input logic [1:0] op,
                                  input logic [2:0] rm, output logic [63:0] res, output logic [4:0] flg);
        logic signed [129:0] hi, lo, v;
        logic [127:0] sig, flr, rem, half, m;
        int e, sh;
        logic neg, nv, up;
        neg = d[64];
        e   = int'(d[63:52]) - 2047;
        sig = 128'({1'b1, d[51:0]});
        nv  = 1'b0;
        rem = '0;
        flr = '0;
        case (op)
            2'd0: begin hi = (130'sd1 <<< 31) - 130'sd1; lo = -(130'sd1 <<< 31); end
            2'd1: begin hi = (130'sd1 <<< 32) - 130'sd1; lo = '0; end
            2'd2: begin hi = (130'sd1 <<< 63) - 130'sd1; lo = -(130'sd1 <<< 63); end
            default: begin hi = (130'sd1 <<< 64) - 130'sd1; lo = '0; end
        endcase
        if (c[8] | c[9]) begin
            v = hi; nv = 1'b1;
        end else if (c[0] | c[7]) begin
            v = neg ? lo : hi; nv = 1'b1;
        end else if (c[3] | c[4]) begin
            v = '0;
        end else if (e >= 64) begin
            v = neg ? lo : hi; nv = 1'b1;
        end else begin
            if (e >= 52) begin
                flr  = sig << (e - 52);
                half = 128'd1;
            end else begin
                sh   = 52 - e;
                if (sh > 100) sh = 100;
                flr  = sig >> sh;
                rem  = sig - (flr << sh);
                half = 128'd1 << (sh - 1);
            end
            case (rm)
                3'd1:    up = 1'b0;
                3'd2:    up = neg && (rem != 0);
                3'd3:    up = !neg && (rem != 0);
                3'd4:    up = rem >= half;
                default: up = (rem > half) || ((rem == half) && flr[0]);
            endcase
            m = flr + 128'(up);
            v = neg ? -$signed({2'b00, m}) : $signed({2'b00, m});
            if (v > hi) begin
                v = hi; nv = 1'b1;
            end else if (v < lo) begin
                v = lo; nv = 1'b1;
            end
        end
        res = op[1] ? v[63:0] : {{32{v[31]}}, v[31:0]};
        flg = {nv, 3'b000, (rem != 0) && !nv};
    endfunction

    task automatic gen_operand();
        int k;
        int bnd[7];
        logic s;
        logic [63:0] r;
        logic [51:0] f;
        logic [11:0] ex;
        logic [9:0]  c;
        bnd = '{30, 31, 32, 62, 63, 64, -1};
        k = $urandom_range(0, 19);
        s = 1'($urandom_range(0, 1));
        r = {$urandom, $urandom};
        f = r[51:0];
        c = s ? (r[60] ? 10'(1 << 1) : 10'(1 << 2)) : (r[60] ? 10'(1 << 6) : 10'(1 << 5));
        case (k)
            0: begin ex = 12'hFFF; c = f[51] ? 10'(1 << 9) : 10'(1 << 8); end
            1: begin ex = 12'hFFF; f = '0; c = s ? 10'(1 << 0) : 10'(1 << 7); end
            2: begin ex = 12'h000; f = '0; c = s ? 10'(1 << 3) : 10'(1 << 4); end
            3: ex = 12'($urandom_range(1000, 2044));
            4: begin ex = 12'(2047 + bnd[$urandom_range(0, 6)]); f = '0; end
            5: begin ex = 12'(2047 + bnd[$urandom_range(0, 6)]); f = ~52'(r[3:0]); end
            default: ex = 12'(2045 + $urandom_range(0, 67));
        endcase
        dif.data_i  = {s, ex, f};
        dif.class_i = c;
        dif.op_i    = 2'($urandom_range(0, 3));
        dif.rm_i    = 3'($urandom_range(0, 7));
    endtask

    // Scoreboard: occupancy, in-order delivery and stall stability.
    initial begin
        logic        held;
        logic [63:0] held_res;
        logic [4:0]  held_flg;
        exp_t        e;
        held = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                sb.delete();
                held = 1'b0;
            end else begin
                chk("ready_o", 64'(dif.ready_o), 64'(!clear && (sb.size() < 3 || dif.ready_i)));
                if (dif.valid_o) begin
                    if (held) begin
                        chk("stall_result", dif.result_o, held_res);
                        chk("stall_flags", 64'(dif.flags_o), 64'(held_flg));
                    end
                    if (dif.ready_i) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_valid_o", 64'(dif.valid_o), 64'd0);
                        end else begin
                            e = sb.pop_front();
                            chk("sb_result", dif.result_o, e.res);
                            chk("sb_flags", 64'(dif.flags_o), 64'(e.flg));
                        end
                        held = 1'b0;
                    end else begin
                        held     = 1'b1;
                        held_res = dif.result_o;
                        held_flg = dif.flags_o;
                    end
                end else begin
                    held = 1'b0;
                end
                if (clear) begin
                    sb.delete();
                    held = 1'b0;
                end else if (dif.valid_i && dif.ready_o) begin
                    model(dif.data_i, dif.class_i, dif.op_i, dif.rm_i, e.res, e.flg);
                    sb.push_back(e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_vec(input vec_t v);
        int lat;
        logic got;
        dif.data_i  = v.data;
        dif.class_i = v.cls;
        dif.op_i    = v.op;
        dif.rm_i    = v.rm;
        dif.valid_i = 1'b1;
        dif.ready_i = 1'b1;
        next_cycle();
        dif.valid_i = 1'b0;
        lat = 1;
        got = 1'b0;
        while (lat < 10 && !got) begin
            @(negedge clock);
            if (dif.valid_o) got = 1'b1;
            else begin
                lat++;
                next_cycle();
            end
        end
        chk({v.name, "_latency"}, 64'(lat), 64'd3);
        chk({v.name, "_result"}, dif.result_o, v.res);
        chk({v.name, "_flags"}, 64'(dif.flags_o), 64'(v.flg));
        next_cycle();
    endtask

    initial begin
        vec_t vecs[16];
        int   sent, cyc;
        logic acc;

        vecs[0]  = '{"rne_2p5",    65'h0_800_4000000000000, 10'(1 << 6), 2'd0, 3'd0, 64'd2, 5'h01};
        vecs[1]  = '{"rmm_2p5",    65'h0_800_4000000000000, 10'(1 << 6), 2'd0, 3'd4, 64'd3, 5'h01};
        vecs[2]  = '{"rtz_2p5",    65'h0_800_4000000000000, 10'(1 << 6), 2'd0, 3'd1, 64'd2, 5'h01};
        vecs[3]  = '{"rdn_m1p5",   65'h1_7FF_8000000000000, 10'(1 << 1), 2'd2, 3'd2, 64'hFFFF_FFFF_FFFF_FFFE, 5'h01};
        vecs[4]  = '{"i32_p2e31",  65'h0_81E_0000000000000, 10'(1 << 6), 2'd0, 3'd0, 64'h0000_0000_7FFF_FFFF, 5'h10};
        vecs[5]  = '{"i32_m2e31",  65'h1_81E_0000000000000, 10'(1 << 1), 2'd0, 3'd0, 64'hFFFF_FFFF_8000_0000, 5'h00};
        vecs[6]  = '{"qnan_u64",   65'h0_FFF_8000000000000, 10'(1 << 9), 2'd3, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'h10};
        vecs[7]  = '{"minf_u32",   65'h1_FFF_0000000000000, 10'(1 << 0), 2'd1, 3'd0, 64'd0, 5'h10};
        vecs[8]  = '{"pzero_i64",  65'h0_000_0000000000000, 10'(1 << 4), 2'd2, 3'd0, 64'd0, 5'h00};
        vecs[9]  = '{"m0p25_rtz",  65'h1_7FD_0000000000000, 10'(1 << 1), 2'd1, 3'd1, 64'd0, 5'h01};
        vecs[10] = '{"m0p25_rdn",  65'h1_7FD_0000000000000, 10'(1 << 1), 2'd1, 3'd2, 64'd0, 5'h10};
        vecs[11] = '{"m0p25_rup",  65'h1_7FD_0000000000000, 10'(1 << 1), 2'd1, 3'd3, 64'd0, 5'h01};
        vecs[12] = '{"i64_p2e63",  65'h0_83E_0000000000000, 10'(1 << 6), 2'd2, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 5'h10};
        vecs[13] = '{"u64_p2e63",  65'h0_83E_0000000000000, 10'(1 << 6), 2'd3, 3'd0, 64'h8000_0000_0000_0000, 5'h00};
        vecs[14] = '{"rne_m0p5",   65'h1_7FE_0000000000000, 10'(1 << 1), 2'd0, 3'd0, 64'd0, 5'h01};
        vecs[15] = '{"rne_3p5",    65'h0_800_C000000000000, 10'(1 << 6), 2'd0, 3'd0, 64'd4, 5'h01};

        reset       = 1'b1;
        clear       = 1'b0;
        dif.valid_i = 1'b0;
        dif.ready_i = 1'b1;
        dif.data_i  = '0;
        dif.class_i = '0;
        dif.op_i    = '0;
        dif.rm_i    = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst_valid_o", 64'(dif.valid_o), 64'd0);
        chk("rst_ready_o", 64'(dif.ready_o), 64'd1);
        chk("rst_result_o", dif.result_o, 64'd0);
        chk("rst_flags_o", 64'(dif.flags_o), 64'd0);
        repeat (2) next_cycle();
        reset = 1'b1;
        next_cycle();

        for (int i = 0; i < 16; i++) apply_vec(vecs[i]);

        // Five back-to-back operands with the consumer stalled for cycles 2..6.
        sent = 0;
        acc  = 1'b0;
        for (cyc = 0; cyc < 20; cyc++) begin
            dif.ready_i = !(cyc >= 2 && cyc <= 6);
            if (sent < 5) begin
                if (!dif.valid_i || acc) gen_operand();
                dif.valid_i = 1'b1;
            end else begin
                dif.valid_i = 1'b0;
            end
            @(negedge clock);
            acc = dif.valid_i && dif.ready_o;
            if (acc) sent++;
            next_cycle();
        end
        dif.valid_i = 1'b0;
        chk("stream_sent", 64'(sent), 64'd5);
        chk("stream_drained", 64'(sb.size()), 64'd0);

        // Fill the stalled pipeline, then reset asynchronously mid-stall.
        dif.ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gen_operand();
            dif.valid_i = 1'b1;
            next_cycle();
        end
        dif.valid_i = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("midrst_valid_o", 64'(dif.valid_o), 64'd0);
        chk("midrst_ready_o", 64'(dif.ready_o), 64'd1);
        chk("midrst_result_o", dif.result_o, 64'd0);
        chk("midrst_flags_o", 64'(dif.flags_o), 64'd0);
        next_cycle();
        reset       = 1'b1;
        dif.ready_i = 1'b1;
        next_cycle();

        // Two operands in flight, then a flush with a new operand offered.
        for (int i = 0; i < 2; i++) begin
            gen_operand();
            dif.valid_i = 1'b1;
            next_cycle();
        end
        gen_operand();
        clear = 1'b1;
        next_cycle();
        clear       = 1'b0;
        dif.valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("clear_valid_o", 64'(dif.valid_o), 64'd0);
            next_cycle();
        end

        // Randomized traffic with random back-pressure and occasional flushes.
        acc = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!dif.valid_i || acc) begin
                dif.valid_i = ($urandom_range(0, 3) != 0);
                if (dif.valid_i) gen_operand();
            end
            dif.ready_i = ($urandom_range(0, 3) != 0);
            clear       = ($urandom_range(0, 99) == 0);
            @(negedge clock);
            acc = dif.valid_i && dif.ready_o;
            next_cycle();
        end
        clear       = 1'b0;
        dif.valid_i = 1'b0;
        dif.ready_i = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) next_cycle();
        repeat (2) next_cycle();
        chk("random_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fp_cvt_f2i.md
# fp_cvt_f2i

Pipelined float-to-integer converter fed directly by the operand-extension stage. Accepts an operand in the 65-bit extended internal format plus its 10-bit class vector, and produces a rounded, saturated 64-bit integer with RISC-V exception flags. Implements FCVT.{W,WU,L,LU}.{S,D} for the FPU execute path. It is a 3-stage pipeline with valid/ready flow control on both sides.

## Interface
- No parameters.
- `reset`  in  1  asynchronous, active-low
- `clock`  in  1  rising-edge clock
- `clear`  in  1  synchronous flush of all stages, applied while `reset` is high
- `valid_i`  in  1  input operand valid
- `ready_o`  out  1  stage 1 can accept an operand
- `data_i`  in  65  extended operand: [64] sign, [63:52] exponent with bias 2047 (0xFFF means Inf/NaN), [51:0] fraction with implicit leading 1
- `class_i`  in  10  one-hot class: 0 -Inf, 1 -norm, 2 -sub, 3 -0, 4 +0, 5 +sub, 6 +norm, 7 +Inf, 8 sNaN, 9 qNaN
- `op_i`  in  2  0 int32, 1 uint32, 2 int64, 3 uint64
- `rm_i`  in  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; codes 5–7 behave as RNE
- `valid_o`  out  1  result valid
- `ready_i`  in  1  consumer accepts the result
- `result_o`  out  64  integer result; 32-bit ops are sign-extended from bit 31
- `flags_o`  out  5  {NV, DZ, OF, UF, NX}; DZ, OF and UF are always 0

## Operation
- **S1 (capture/decode).**
  - E = exp − 2047, signed 13 bits.
  - Sets `special` if class bit 0, 7, 8 or 9 is set.
  - Sets `zero` if class bit 3 or 4 is set.
  - Sets `big` if E ≥ 64.
  - Subnormals are treated like normals, with the true exponent already encoded in the extended format.
- **S2 (align).**
  - Significand is {1, frac}, 53 bits.
  - Produces I (64-bit integer part of |v|), R (first bit below the LSB) and T (sticky: OR of all lower bits).
  - E ≤ −2: I = 0, R = 0, T = 1.
  - E = −1: I = 0, R = 1, T = |frac.
  - `zero`: I, R and T are all 0.
- **S3 (round/range/pack).**
  - Increment term inc:
    - RNE: R & (T | I[0])
    - RTZ: 0
    - RDN: sign & (R | T)
    - RUP: ~sign & (R | T)
    - RMM: R
  - M = I + inc, computed at 65 bits.
  - Valid magnitude range:
    - int32: positive M ≤ 2^31−1, negative M ≤ 2^31
    - uint32: positive M ≤ 2^32−1
    - int64: positive M ≤ 2^63−1, negative M ≤ 2^63
    - uint64: positive M ≤ 2^64−1
    - Negative unsigned: valid only if M = 0
  - Out of range, `big`, or `special` sets NV and saturates:
    - NaN and positive overflow give the type max: 0x7FFFFFFF, 0xFFFFFFFF, 0x7FFF_FFFF_FFFF_FFFF or 0xFFFF_FFFF_FFFF_FFFF (32-bit values then sign-extended).
    - Negative overflow gives the type min: 0x80000000 for int32, 0x8000_0000_0000_0000 for int64, 0 for unsigned.
  - Otherwise the result is ±M in two's complement, with 32-bit ops sign-extended from bit 31.
  - NX = (R | T) & ~NV. NV and NX are never both set.

## Timing
- **Latency.** Exactly 3 cycles from the accepting edge (`valid_i & ready_o`) to `valid_o` when `ready_i` stays high. Throughput is 1 per cycle.
- **Stage advance.** A stage loads when it is empty or its contents advance in the same cycle. Full stages hold while the downstream stage holds.
- **`ready_o`.** Equals ~v1 | (S1 advances this cycle). It is combinational from `ready_i` through the stage valids.
- **Stall behaviour.**
  - With `ready_i` low, up to 3 operands are held.
  - `ready_o` goes low only when all three stages are full.
  - `result_o` and `flags_o` stay stable while `valid_o & ~ready_i`.
  - Results are delivered in order, with no loss or duplication.
- **Reset (`reset` = 0, asynchronous).** Stage valids clear, so `valid_o` = 0 and `ready_o` = 1; `result_o` and `flags_o` read 0. Applies mid-stall as well; in-flight operands are discarded.
- **`clear`.**
  - Zeroes all stage valids at the next edge.
  - An input presented in the same cycle is not accepted, and `ready_o` is 0 during `clear`.
- **Simultaneous events.** Output handoff and a new input acceptance in the same cycle are both honoured.

## Test plan
- **Rounding, int32.** 2.5 (data 0x0_800_4000000000000) → RNE result 2, flags 0x01; RMM 3, flags 0x01; RTZ 2, flags 0x01.
- **Negative, int64.** −1.5 (0x1_7FF_8000000000000), RDN → 0xFFFF_FFFF_FFFF_FFFE, flags 0x01.
- **int32 bounds.**
  - +2^31 (exp 0x81E) → 0x0000_0000_7FFF_FFFF, flags 0x10.
  - −2^31 → 0xFFFF_FFFF_8000_0000, flags 0x00.
- **Specials.**
  - qNaN (class bit 9) to uint64 → 0xFFFF_FFFF_FFFF_FFFF, flags 0x10.
  - −Inf to uint32 → 0, flags 0x10.
  - +0 to int64 → 0, flags 0x00.
- **Negative to unsigned.** −0.25 to uint32:
  - RTZ → 0, flags 0x01.
  - RDN → 0, flags 0x10.
  - RUP → 0, flags 0x01.
- **Flow control.**
  - 5 back-to-back inputs with `ready_i` low for cycles 2–6: `ready_o` low once 3 are held, all 5 outputs in order, outputs stable during the stall.
  - Then `reset` asserted mid-stall: `valid_o` drops immediately, `ready_o` = 1.
  - `clear` with 2 in flight: no results emerge.
